branch_resolver: RTL and testbench

- Producer side of the branch-result interface: owns the branch history table (BHT) and predicts at Fetch.
- Tracks each prediction through D into X and compares it with the actual outcome from the X-stage branch unit.
- Drives the 3-bit result code that the flush logic decodes; result == 3'b100 flushes the FD registers.
- Trains the BHT on every resolved branch.

---
 rtl/branch_resolver_pkg.sv | 14 +
 rtl/branch_resolver_bht_counter_table.sv | 29 ++
 rtl/branch_resolver.sv | 50 +++++
 tb/tb_branch_resolver.sv | 133 +++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: result codes, counter reset value and tracking-entry type
package branch_resolver_pkg;
  localparam int BHT_IDX_BITS = 6;
  localparam logic [2:0] RES_NONE       = 3'b000;
  localparam logic [2:0] RES_TAKEN_OK   = 3'b001;
  localparam logic [2:0] RES_NT_OK      = 3'b010;
  localparam logic [2:0] RES_MISPREDICT = 3'b100;
  localparam logic [1:0] CTR_WEAK_NT    = 2'b01;
  typedef struct packed {
    logic                    valid;
    logic [BHT_IDX_BITS-1:0] idx;
    logic                    pred;
  } track_t;
endpackage

// File: rtl/branch_resolver_bht_counter_table.sv
// bht_counter_table: 2-bit saturating counters, async read, sync update and reset
module bht_counter_table
  import branch_resolver_pkg::*;
#(
  parameter int IDX_BITS = BHT_IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);
  logic [1:0] bht [2**IDX_BITS];
  logic [1:0] cur, nxt;
  assign rd_ctr = bht[rd_idx];
  assign cur = bht[wr_idx];
  always_comb
    nxt = wr_taken ? ((cur == 2'b11) ? cur : cur + 2'd1)
                   : ((cur == 2'b00) ? cur : cur - 2'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_BITS; i++) bht[i] <= CTR_WEAK_NT;
    end else if (wr_en) begin
      bht[wr_idx] <= nxt;
    end
  end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: BHT prediction at fetch, D/X tracking, X-stage resolution and training
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int IDX_BITS = BHT_IDX_BITS,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] f_pc,
  input  logic                f_valid,
  input  logic                stall,
  input  logic                x_is_branch,
  input  logic                x_taken,
  output logic                predict_taken,
  output logic [2:0]          result
);
  track_t d, x;
  logic [IDX_BITS-1:0] idx;
  logic [1:0] rd_ctr;
  logic mispredict, unused_pc;
  assign idx = f_pc[IDX_BITS+1:2];
  assign unused_pc = ^{f_pc[PC_WIDTH-1:IDX_BITS+2], f_pc[1:0], rd_ctr[0]};
  assign predict_taken = rd_ctr[1];
  always_comb
    result = (!x.valid || !x_is_branch) ? RES_NONE
           : (x.pred != x_taken)        ? RES_MISPREDICT
           : x_taken                    ? RES_TAKEN_OK
           :                              RES_NT_OK;
  assign mispredict = result == RES_MISPREDICT;
  bht_counter_table #(.IDX_BITS(IDX_BITS)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (!stall && x.valid && x_is_branch),
    .wr_idx   (x.idx),
    .wr_taken (x_taken)
  );
  // a mispredict squashes both in-flight entries, including this cycle's fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      d <= '0;
      x <= '0;
    end else if (!stall) begin
      x <= mispredict ? '0 : d;
      d <= mispredict ? '0 : '{valid: f_valid, idx: idx, pred: predict_taken};
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed checks of prediction, resolution codes, flush, stall and reset
module tb_branch_resolver;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] f_pc = 0;
  logic        f_valid = 0;
  logic        stall = 0;
  logic        x_is_branch = 0;
  logic        x_taken = 0;
  logic        predict_taken;
  logic [2:0]  result;
  int tests = 0;
  int failed = 0;

  branch_resolver dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_valid(f_valid), .stall(stall),
    .x_is_branch(x_is_branch), .x_taken(x_taken),
    .predict_taken(predict_taken), .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1; f_valid = 0; x_is_branch = 0; stall = 0;
    tick; tick;
    rst = 0;
  endtask

  // fetch pc, let it reach X with one bubble, then resolve it
  task automatic issue(input string tag, input logic [31:0] pc, input logic tk,
                       input logic exp_pred, input logic [2:0] exp_res);
    f_pc = pc; f_valid = 1; x_is_branch = 0; #1;
    chk({tag, "_pred"}, 32'(predict_taken), 32'(exp_pred));
    tick;
    f_valid = 0; f_pc = 0;
    tick;
    x_is_branch = 1; x_taken = tk; #1;
    chk({tag, "_res"}, 32'(result), 32'(exp_res));
    tick;
    x_is_branch = 0;
  endtask

  initial begin
    int bad;
    do_reset;
    f_pc = 32'h40; #1;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_pred40", 32'(predict_taken), 32'h0);
    chk("rst_bht16", 32'(dut.u_bht.bht[16]), 32'h1);
    issue("nt1", 32'h40, 1'b0, 1'b0, 3'b010);
    chk("nt1_bht16", 32'(dut.u_bht.bht[16]), 32'h0);

    do_reset;
    issue("tk1", 32'h40, 1'b1, 1'b0, 3'b100);
    chk("tk1_bht16", 32'(dut.u_bht.bht[16]), 32'h2);
    issue("tk2", 32'h40, 1'b1, 1'b1, 3'b001);
    chk("tk2_bht16", 32'(dut.u_bht.bht[16]), 32'h3);
    issue("tk3", 32'h40, 1'b1, 1'b1, 3'b001);
    chk("tk3_bht16_sat", 32'(dut.u_bht.bht[16]), 32'h3);
    issue("alias", 32'hFFFF_FF40, 1'b1, 1'b1, 3'b001);
    chk("alias_bht16_sat", 32'(dut.u_bht.bht[16]), 32'h3);

    // read/update collision on idx 5: pre-update value is seen
    f_pc = 32'h14; f_valid = 1; tick;
    f_valid = 0; tick;
    f_valid = 1; x_is_branch = 1; x_taken = 1; #1;
    chk("col_pred_same", 32'(predict_taken), 32'h0);
    chk("col_res", 32'(result), 32'h4);
    tick;
    x_is_branch = 0; f_valid = 0; #1;
    chk("col_pred_next", 32'(predict_taken), 32'h1);

    // mispredict with a valid D behind it
    f_pc = 32'h80; f_valid = 1; tick;
    f_pc = 32'h84; tick;
    f_valid = 0; x_is_branch = 1; x_taken = 1; #1;
    chk("flush_res", 32'(result), 32'h4);
    tick;
    chk("flush_next", 32'(result), 32'h0);
    tick;
    chk("flush_next2", 32'(result), 32'h0);
    chk("flush_bht33", 32'(dut.u_bht.bht[33]), 32'h1);
    x_is_branch = 0;

    // mispredict held under stall
    f_pc = 32'hC0; f_valid = 1; tick;
    f_valid = 0; tick;
    stall = 1; x_is_branch = 1; x_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_res%0d", i), 32'(result), 32'h4);
      chk($sformatf("stall_bht%0d", i), 32'(dut.u_bht.bht[48]), 32'h1);
      tick;
    end
    stall = 0; #1;
    chk("unstall_res", 32'(result), 32'h4);
    tick;
    chk("unstall_next", 32'(result), 32'h0);
    chk("unstall_bht48", 32'(dut.u_bht.bht[48]), 32'h2);
    x_is_branch = 0;

    // reset while a branch in X would train
    f_pc = 32'h0C; f_valid = 1; tick;
    f_valid = 0; tick;
    x_is_branch = 1; x_taken = 1; #1;
    chk("pre_rst_res", 32'(result), 32'h4);
    rst = 1; tick;
    rst = 0; #1;
    chk("mid_rst_res", 32'(result), 32'h0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.u_bht.bht[i] !== 2'b01) bad++;
    chk("mid_rst_all_ctr", 32'(bad), 32'h0);
    f_pc = 32'h40; #1;
    chk("mid_rst_pred40", 32'(predict_taken), 32'h0);
    x_is_branch = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
